// File: rtl/mips_mem_arbiter.sv
// Shares one Avalon-style memory bus between the core's instruction-fetch and data ports.
// The core is stalled via cpu_clock_enable until its fetch and optional data access are done.
// After that it gets a single commit cycle.
module mips_mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_active,
    input  logic [31:0] cpu_instr_address,
    output logic [31:0] cpu_instr_readdata,
    input  logic [31:0] cpu_data_address,
    input  logic        cpu_data_read,
    input  logic        cpu_data_write,
    input  logic [31:0] cpu_data_writedata,
    output logic [31:0] cpu_data_readdata,
    output logic        cpu_clock_enable,
    output logic [31:0] bus_address,
    output logic        bus_read,
    output logic        bus_write,
    output logic [31:0] bus_writedata,
    output logic [3:0]  bus_byteenable,
    input  logic [31:0] bus_readdata,
    input  logic        bus_waitrequest,
    output logic        bus_timeout
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] WaitLimit = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        StFetch,
        StData,
        StCommit,
        StHalt
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     instr_q, instr_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [CntW-1:0] wait_q, wait_d;
    logic            timeout_q, timeout_d;
    logic            rd, wr;
    logic [31:0]     addr;

    // Next-state, latch updates, wait counting and raw bus strobes.
    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        rdata_d   = rdata_q;
        wait_d    = '0;
        timeout_d = timeout_q;
        rd        = 1'b0;
        wr        = 1'b0;
        addr      = {cpu_instr_address[31:2], 2'b00};

        unique case (state_q)
            StFetch: begin
                rd = 1'b1;
                if (!bus_waitrequest) begin
                    instr_d = bus_readdata;
                    state_d = StData;
                end
            end
            StData: begin
                addr = {cpu_data_address[31:2], 2'b00};
                // A store takes precedence over a simultaneous load request.
                if (cpu_data_write) begin
                    wr = 1'b1;
                end else if (cpu_data_read) begin
                    rd = 1'b1;
                end
                if (!(cpu_data_read || cpu_data_write)) begin
                    state_d = StCommit;
                end else if (!bus_waitrequest) begin
                    if (!cpu_data_write) begin
                        rdata_d = bus_readdata;
                    end
                    state_d = StCommit;
                end
            end
            StCommit: begin
                state_d = cpu_active ? StFetch : StHalt;
            end
            StHalt: begin
                state_d = StHalt;
            end
        endcase

        // Counter runs only while a stalled strobe stays in one state; anything else clears it.
        if ((rd || wr) && bus_waitrequest) begin
            if (wait_q >= WaitLimit) begin
                timeout_d = 1'b1;
                state_d   = StHalt;
            end else begin
                wait_d = wait_q + CntW'(1);
            end
        end
    end

    // State and latched data registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StFetch;
            instr_q   <= '0;
            rdata_q   <= '0;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            rdata_q   <= rdata_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    // Outputs: strobes are gated by reset so an in-flight access drops without a clock edge.
    always_comb begin
        bus_read           = rd & ~reset;
        bus_write          = wr & ~reset;
        bus_address        = addr;
        bus_writedata      = cpu_data_writedata;
        bus_byteenable     = 4'hF;
        cpu_clock_enable   = reset | (state_q == StCommit);
        cpu_instr_readdata = instr_q;
        cpu_data_readdata  = rdata_q;
        bus_timeout        = timeout_q;
    end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Bench for mips_mem_arbiter: directed scenarios plus randomized instruction streams.
// Each instruction is checked against a transaction-level model of the bus cycles.
module tb_mips_mem_arbiter;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_active;
    logic [31:0] cpu_instr_address;
    logic [31:0] cpu_instr_readdata;
    logic [31:0] cpu_data_address;
    logic        cpu_data_read;
    logic        cpu_data_write;
    logic [31:0] cpu_data_writedata;
    logic [31:0] cpu_data_readdata;
    logic        cpu_clock_enable;
    logic [31:0] bus_address;
    logic        bus_read;
    logic        bus_write;
    logic [31:0] bus_writedata;
    logic [3:0]  bus_byteenable;
    logic [31:0] bus_readdata;
    logic        bus_waitrequest;
    logic        bus_timeout;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_instr;
    logic [31:0] exp_load;

    mips_mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk                (clk),
        .reset              (reset),
        .cpu_active         (cpu_active),
        .cpu_instr_address  (cpu_instr_address),
        .cpu_instr_readdata (cpu_instr_readdata),
        .cpu_data_address   (cpu_data_address),
        .cpu_data_read      (cpu_data_read),
        .cpu_data_write     (cpu_data_write),
        .cpu_data_writedata (cpu_data_writedata),
        .cpu_data_readdata  (cpu_data_readdata),
        .cpu_clock_enable   (cpu_clock_enable),
        .bus_address        (bus_address),
        .bus_read           (bus_read),
        .bus_write          (bus_write),
        .bus_writedata      (bus_writedata),
        .bus_byteenable     (bus_byteenable),
        .bus_readdata       (bus_readdata),
        .bus_waitrequest    (bus_waitrequest),
        .bus_timeout        (bus_timeout)
    );

    always #5 clk = ~clk;

    // {bus_read, bus_write, cpu_clock_enable}
    function automatic logic [31:0] ctl();
        return {29'd0, bus_read, bus_write, cpu_clock_enable};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Assert reset for one full cycle; reset is left high for the caller to release.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_ctl", ctl(), 32'b001);
        @(negedge clk);
        #1;
        chk("rst_ctl_hold", ctl(), 32'b001);
        chk("rst_timeout", 32'(bus_timeout), 32'd0);
        chk("rst_instr", cpu_instr_readdata, 32'd0);
        chk("rst_load", cpu_data_readdata, 32'd0);
        exp_instr = '0;
        exp_load  = '0;
    endtask

    // One instruction: fetch (w1 waits), optional data access (w2 waits), commit.
    // kind: 0 none, 1 load, 2 store, 3 store with read also asserted.
    task automatic run_instr(input logic [31:0] iaddr, input logic [31:0] iword, input int kind,
                             input logic [31:0] daddr, input logic [31:0] wdata,
                             input logic [31:0] ldata, input int w1, input int w2,
                             input logic active);
        for (int i = 0; i <= w1; i++) begin
            @(negedge clk);
            if (i == 0) begin
                reset              = 1'b0;
                cpu_instr_address  = iaddr;
                cpu_data_address   = daddr;
                cpu_data_read      = (kind == 1) || (kind == 3);
                cpu_data_write     = (kind >= 2);
                cpu_data_writedata = wdata;
                cpu_active         = active;
            end
            bus_waitrequest = (i < w1);
            bus_readdata    = (i < w1) ? $urandom : iword;
            #1;
            chk("fetch_ctl", ctl(), 32'b100);
            chk("fetch_addr", bus_address, {iaddr[31:2], 2'b00});
            chk("fetch_hold", cpu_instr_readdata, exp_instr);
        end
        exp_instr = iword;
        if (kind == 0) begin
            @(negedge clk);
            bus_waitrequest = 1'($urandom_range(0, 1));
            bus_readdata    = $urandom;
            #1;
            chk("pass_ctl", ctl(), 32'b000);
            chk("pass_instr", cpu_instr_readdata, exp_instr);
        end else begin
            for (int i = 0; i <= w2; i++) begin
                @(negedge clk);
                bus_waitrequest = (i < w2);
                bus_readdata    = (i < w2) ? $urandom : ldata;
                #1;
                chk("data_ctl", ctl(), (kind >= 2) ? 32'b010 : 32'b100);
                chk("data_addr", bus_address, {daddr[31:2], 2'b00});
                chk("data_be", 32'(bus_byteenable), 32'hF);
                chk("data_instr", cpu_instr_readdata, exp_instr);
                if (kind >= 2) chk("data_wdata", bus_writedata, wdata);
            end
        end
        if (kind == 1) exp_load = ldata;
        @(negedge clk);
        bus_waitrequest = 1'($urandom_range(0, 1));
        #1;
        chk("commit_ctl", ctl(), 32'b001);
        chk("commit_load", cpu_data_readdata, exp_load);
    endtask

    initial begin
        reset              = 1'b1;
        cpu_active         = 1'b1;
        cpu_instr_address  = '0;
        cpu_data_address   = '0;
        cpu_data_read      = 1'b0;
        cpu_data_write     = 1'b0;
        cpu_data_writedata = '0;
        bus_readdata       = '0;
        bus_waitrequest    = 1'b0;
        exp_instr          = '0;
        exp_load           = '0;
        #1;
        chk("init_ctl", ctl(), 32'b001);
        chk("init_timeout", 32'(bus_timeout), 32'd0);
        chk("init_instr", cpu_instr_readdata, 32'd0);
        chk("init_load", cpu_data_readdata, 32'd0);

        // Directed: ADDIU, LW with 2 waits, SW with read also asserted.
        run_instr(32'hBFC00000, 32'h24080001, 0, 32'h0, 32'h0, 32'h0, 0, 0, 1'b1);
        run_instr(32'hBFC00004, 32'h8C090002, 1, 32'h00001002, 32'h0, 32'hDEADBEEF, 0, 2, 1'b1);
        run_instr(32'hBFC00008, 32'hAC0A0000, 3, 32'h00002001, 32'h12345678, 32'h0, 1, 0, 1'b1);

        // Randomized stream; waits up to TO-1 stay just under the abort threshold.
        for (int n = 0; n < 40; n++) begin
            run_instr($urandom, $urandom, int'($urandom_range(0, 3)), $urandom, $urandom,
                      $urandom, int'($urandom_range(0, TO - 1)),
                      int'($urandom_range(0, TO - 1)), 1'b1);
        end

        // Halt: cpu_active low at commit, then no further activity.
        run_instr(32'hBFC00100, 32'h0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus_waitrequest = 1'($urandom_range(0, 1));
            #1;
            chk("halt_ctl", ctl(), 32'b000);
        end

        // Reset asserted mid-DATA during a stalled load.
        do_reset();
        @(negedge clk);
        reset             = 1'b0;
        cpu_instr_address = 32'h00400010;
        cpu_data_address  = 32'h00003004;
        cpu_data_read     = 1'b1;
        cpu_data_write    = 1'b0;
        bus_waitrequest   = 1'b0;
        bus_readdata      = 32'h8C0B0000;
        #1;
        chk("mid_fetch_ctl", ctl(), 32'b100);
        @(negedge clk);
        bus_waitrequest = 1'b1;
        #1;
        chk("mid_data_ctl", ctl(), 32'b100);
        chk("mid_data_addr", bus_address, 32'h00003004);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_ctl", ctl(), 32'b001);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_ctl", ctl(), 32'b100);
        chk("post_rst_addr", bus_address, 32'h00400010);

        // Timeout: waitrequest stuck during a fetch.
        do_reset();
        @(negedge clk);
        reset             = 1'b0;
        cpu_instr_address = 32'h00400023;
        bus_waitrequest   = 1'b1;
        for (int i = 0; i < int'(TO); i++) begin
            if (i > 0) @(negedge clk);
            #1;
            chk("to_strobe", ctl(), 32'b100);
            chk("to_flag_low", 32'(bus_timeout), 32'd0);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus_waitrequest = 1'($urandom_range(0, 1));
            #1;
            chk("to_halt_ctl", ctl(), 32'b000);
            chk("to_flag", 32'(bus_timeout), 32'd1);
        end
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_mem_arbiter.md
Name: mips_mem_arbiter

Overview:
Shares one Avalon-style memory bus between the CPU core's instruction-fetch port and its data port. It stalls the core through cpu_clock_enable until both accesses for the current instruction have completed. It sits between the Harvard-interface core and the single-ported system memory. Every instruction costs one fetch, an optional data access, and a one-cycle commit.

Parameters:
TIMEOUT_CYCLES, 64, maximum consecutive waitrequest cycles tolerated on one bus access before the block aborts; must be at least 1.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
cpu_active  input  1  core active flag; 0 means halted
cpu_instr_address  input  32  core fetch address
cpu_instr_readdata  output  32  latched instruction word for the core
cpu_data_address  input  32  core data address
cpu_data_read  input  1  core load request
cpu_data_write  input  1  core store request
cpu_data_writedata  input  32  core store data
cpu_data_readdata  output  32  latched load data for the core
cpu_clock_enable  output  1  core advances only on edges where this is 1
bus_address  output  32  word-aligned bus address
bus_read  output  1  bus read strobe
bus_write  output  1  bus write strobe
bus_writedata  output  32  bus write data
bus_byteenable  output  4  byte lanes; always 4'hF
bus_readdata  input  32  bus read data
bus_waitrequest  input  1  slave stall; an access completes on an edge where the strobe is 1 and waitrequest is 0
bus_timeout  output  1  sticky abort flag

Behaviour:
- States: FETCH, DATA, COMMIT, HALT.
- Reset (async) sets:
  - state=FETCH, both latched data registers=0, wait counter=0, bus_timeout=0.
  - cpu_clock_enable = reset OR (state==COMMIT). It is therefore 1 throughout reset, so the core's register-file clear can take effect.
- While reset=1, bus_read and bus_write are forced to 0.
- Bus outputs are combinational from state and core ports. They are stable during waitrequest because the core is not enabled.
- FETCH:
  - Drives bus_read=1, bus_address={cpu_instr_address[31:2],2'b00}.
  - On completion, latch bus_readdata into cpu_instr_readdata.
  - Next state: DATA if cpu_data_read|cpu_data_write, sampled on that edge against the new instruction (the core decodes combinationally from cpu_instr_readdata). Otherwise COMMIT.
  - The latch is therefore made one edge earlier so the core sees the new word before the decision. Implementation: latch on completion, go to DATA_CHECK decision via one extra evaluation in DATA.
- DATA:
  - On entry, if neither cpu_data_read nor cpu_data_write is 1 (non-memory instruction), go straight to COMMIT with no strobe.
  - Otherwise drive bus_address={cpu_data_address[31:2],2'b00}.
  - cpu_data_write=1 gives bus_write=1 and bus_writedata=cpu_data_writedata.
  - Otherwise bus_read=1; on completion, latch bus_readdata into cpu_data_readdata.
  - Read and write both asserted: write wins, no read issued.
  - On completion, go to COMMIT.
- COMMIT:
  - cpu_clock_enable=1 for exactly one cycle, no bus strobes.
  - Next: FETCH if cpu_active=1, else HALT.
- HALT: no strobes, cpu_clock_enable=0. Left only by reset.
- Latency with zero-wait memory:
  - non-memory instruction 3 cycles (FETCH, DATA pass-through, COMMIT);
  - load/store 3 cycles;
  - each waitrequest cycle adds 1.
- Wait counter:
  - Counts consecutive cycles with a strobe asserted and bus_waitrequest=1.
  - Clears on completion and on every state change.
  - If it reaches TIMEOUT_CYCLES: set bus_timeout, drop strobes, go to HALT. bus_timeout clears only on reset.
- cpu_data_readdata holds its last value across fetches and stores. cpu_instr_readdata holds until the next fetch completes.
- Reset asserted mid-access: strobes drop immediately (combinational), state returns to FETCH, and the in-flight access is abandoned without completion.
- Address wrap: no arithmetic is performed on addresses; the low 2 bits are simply masked.

Test Plan:
- Zero-wait fetch of ADDIU at 32'hBFC00000 with bus_waitrequest=0: bus_read=1 with bus_address=32'hBFC00000 in cycle 1; DATA pass-through in cycle 2; cpu_clock_enable=1 in cycle 3 only; next fetch in cycle 4.
- LW at 32'hBFC00004, data address 32'h00001002, memory returns 32'hDEADBEEF with 2 wait cycles: data read issued at bus_address=32'h00001000 and held 3 cycles; cpu_data_readdata=32'hDEADBEEF; cpu_clock_enable pulses once.
- SW with cpu_data_writedata=32'h12345678 and simultaneous cpu_data_read=1: only bus_write=1, bus_byteenable=4'hF, bus_read stays 0.
- TIMEOUT_CYCLES=4 with bus_waitrequest stuck at 1 during a fetch: strobe held exactly 4 cycles, then bus_timeout=1, state HALT, cpu_clock_enable stays 0 permanently until reset.
- cpu_active=0 at COMMIT: one final cpu_clock_enable pulse, then no further bus strobes for 20 cycles.
- Reset asserted asynchronously mid-DATA while bus_waitrequest=1: bus_read and bus_write fall without a clock edge; cpu_clock_enable=1 while reset is high; after release the first access is a fetch.
